pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush that inserts a bubble, and a saturating back-pressure counter. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces per-stage hand-written registers whose stall input is global and combinational. Data and control fields are carried separately, so a flush or bubble zeroes control (a NOP) while the data payload is left untouched.

---
 rtl/pipe_skid_stage.sv | 117 +++++++++++
 tb/tb_pipe_skid_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// bubble-inserting flush and a saturating back-pressure counter.
module pipe_skid_stage #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 24,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;

   generate
      if (SKID != 0) begin : g_skid
         localparam logic [1:0] ST_EMPTY = 2'd0;
         localparam logic [1:0] ST_FULL  = 2'd1;
         localparam logic [1:0] ST_SKID  = 2'd2;

         logic [1:0]        state;
         logic [DATA_W-1:0] skid_data;
         logic [CTRL_W-1:0] skid_ctrl;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state     <= ST_EMPTY;
               main_data <= '0;
               main_ctrl <= '0;
               skid_data <= '0;
               skid_ctrl <= '0;
            end else if (flush) begin
               // bubble: control zeroed, data payload left in place
               state     <= ST_EMPTY;
               main_ctrl <= '0;
               skid_ctrl <= '0;
            end else begin
               case (state)
                  ST_EMPTY: if (in_valid) begin
                     main_data <= in_data;
                     main_ctrl <= in_ctrl;
                     state     <= ST_FULL;
                  end
                  ST_FULL: begin
                     if (out_ready) begin
                        if (in_valid) begin
                           main_data <= in_data;
                           main_ctrl <= in_ctrl;
                        end else begin
                           state <= ST_EMPTY;
                        end
                     end else if (in_valid) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        state     <= ST_SKID;
                     end
                  end
                  ST_SKID: if (out_ready) begin
                     main_data <= skid_data;
                     main_ctrl <= skid_ctrl;
                     state     <= ST_FULL;
                  end
                  default: state <= ST_EMPTY;
               endcase
            end
         end

         // decoded from state only, so no combinational path from out_ready
         assign in_ready  = (state != ST_SKID);
         assign out_valid = (state != ST_EMPTY);
      end else begin : g_flat
         logic vld;

         assign in_ready  = !vld | out_ready;
         assign out_valid = vld;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld       <= 1'b0;
               main_data <= '0;
               main_ctrl <= '0;
            end else if (flush) begin
               vld       <= 1'b0;
               main_ctrl <= '0;
            end else if (in_valid && in_ready) begin
               vld       <= 1'b1;
               main_data <= in_data;
               main_ctrl <= in_ctrl;
            end else if (vld && out_ready) begin
               vld <= 1'b0;
            end
         end
      end
   endgenerate

   assign out_data = main_data;
   assign out_ctrl = out_valid ? main_ctrl : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: SKID=1 instance (index 0) and SKID=0 instance (index 1)
// checked against an occupancy/queue model of the stage.
module tb_pipe_skid_stage;
   localparam int DW = 32;
   localparam int CW = 8;
   localparam int NW = 4;
   localparam int VW = 2 + DW + CW + NW;
   localparam int CMAX = (1 << NW) - 1;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]         in_valid, out_ready, flush;
   logic [1:0][DW-1:0] in_data;
   logic [1:0][CW-1:0] in_ctrl;

   logic          a_rdy, a_vld, b_rdy, b_vld;
   logic [DW-1:0] a_dat, b_dat;
   logic [CW-1:0] a_ctl, b_ctl;
   logic [NW-1:0] a_cnt, b_cnt;

   int n_chk = 0;
   int n_fail = 0;

   logic [CW+DW-1:0] q [2][$];
   logic [DW-1:0]    last [2];
   int               cnt [2];

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(a_rdy),
      .in_data(in_data[0]), .in_ctrl(in_ctrl[0]), .out_valid(a_vld),
      .out_ready(out_ready[0]), .out_data(a_dat), .out_ctrl(a_ctl),
      .flush(flush[0]), .stall_cnt(a_cnt));

   pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_flat (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(b_rdy),
      .in_data(in_data[1]), .in_ctrl(in_ctrl[1]), .out_valid(b_vld),
      .out_ready(out_ready[1]), .out_data(b_dat), .out_ctrl(b_ctl),
      .flush(flush[1]), .stall_cnt(b_cnt));

   // Model: the stage is a FIFO of held words; capacity 2 for the skid variant,
   // 1 with pass-through ready for the flat variant.
   function automatic logic exp_rdy(int d);
      if (d == 0) return q[0].size() < 2;
      return q[1].size() == 0 || out_ready[1];
   endfunction

   function automatic logic [VW-1:0] exp_vec(int d);
      logic [CW+DW-1:0] w;
      logic             v;
      v = q[d].size() > 0;
      w = v ? q[d][0] : {{CW{1'b0}}, last[d]};
      return {exp_rdy(d), v, w[DW-1:0], v ? w[CW+DW-1:DW] : {CW{1'b0}}, NW'(cnt[d])};
   endfunction

   function automatic logic [VW-1:0] obs(int d);
      if (d == 0) return {a_rdy, a_vld, a_dat, a_ctl, a_cnt};
      return {b_rdy, b_vld, b_dat, b_ctl, b_cnt};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         q[d].delete();
         last[d] = '0;
         cnt[d]  = 0;
      end
   endtask

   task automatic idle();
      in_valid  = 2'b00;
      out_ready = 2'b00;
      flush     = 2'b00;
   endtask

   // advance one clock and apply the same edge to the model
   task automatic tick();
      logic [1:0] ai, ao;
      for (int d = 0; d < 2; d++) begin
         ai[d] = in_valid[d] && exp_rdy(d);
         ao[d] = (q[d].size() > 0) && out_ready[d];
         if (q[d].size() > 0 && !out_ready[d] && cnt[d] < CMAX) cnt[d]++;
      end
      @(posedge clk);
      if (rst) model_reset();
      else for (int d = 0; d < 2; d++) begin
         if (flush[d]) q[d].delete();
         else begin
            if (ao[d]) void'(q[d].pop_front());
            if (ai[d]) q[d].push_back({in_ctrl[d], in_data[d]});
         end
         if (q[d].size() > 0) last[d] = q[d][0][DW-1:0];
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      in_data = '0;
      in_ctrl = '0;
      model_reset();
      #2;
      n_chk++;
      if ({a_rdy, a_vld, a_dat, a_ctl, a_cnt} !== {1'b1, 1'b0, {DW{1'b0}}, {CW{1'b0}}, {NW{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_skid got %h expected rdy=1 rest 0", obs(0));
      end
      n_chk++;
      if ({b_rdy, b_vld, b_dat, b_ctl, b_cnt} !== {1'b1, 1'b0, {DW{1'b0}}, {CW{1'b0}}, {NW{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_flat got %h expected rdy=1 rest 0", obs(1));
      end
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (obs(d) !== exp_vec(d)) begin
            n_fail++;
            $display("FAIL reset_release d%0d got %h expected %h", d, obs(d), exp_vec(d));
         end
      end
   endtask

   task automatic test_stream();
      for (int k = 1; k <= 9; k++) begin
         in_valid  = (k <= 8) ? 2'b11 : 2'b00;
         out_ready = 2'b11;
         for (int d = 0; d < 2; d++) begin
            in_data[d] = DW'(k);
            in_ctrl[d] = CW'($urandom);
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs(d) !== exp_vec(d)) begin
               n_fail++;
               $display("FAIL stream d%0d got %h expected %h", d, obs(d), exp_vec(d));
            end
         end
         if (k >= 2) begin
            n_chk++;
            if (!a_vld || a_dat !== DW'(k - 1) || !b_vld || b_dat !== DW'(k - 1)) begin
               n_fail++;
               $display("FAIL stream_order cyc%0d got %0d/%0d expected %0d", k, a_dat, b_dat, k - 1);
            end
         end
         n_chk++;
         if (a_rdy !== 1'b1 || a_cnt !== '0) begin
            n_fail++;
            $display("FAIL stream_rdy_cnt got rdy=%b cnt=%0d expected rdy=1 cnt=0", a_rdy, a_cnt);
         end
         tick();
      end
   endtask

   task automatic test_back_pressure();
      int nxt [2];
      int got [2][$];
      int low_rdy = 0;
      int cyc = 0;
      nxt[0] = 1;
      nxt[1] = 1;
      while ((got[0].size() < 4 || got[1].size() < 4) && cyc < 30) begin
         for (int d = 0; d < 2; d++) begin
            in_valid[d] = nxt[d] <= 4;
            in_data[d]  = DW'(nxt[d]);
            in_ctrl[d]  = CW'(8'h10 + nxt[d]);
         end
         out_ready = (cyc >= 1 && cyc <= 3) ? 2'b00 : 2'b11;
         #1;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs(d) !== exp_vec(d)) begin
               n_fail++;
               $display("FAIL back_pressure d%0d cyc%0d got %h expected %h", d, cyc, obs(d), exp_vec(d));
            end
         end
         if (!a_rdy) low_rdy++;
         if (a_vld && out_ready[0]) got[0].push_back(int'(a_dat));
         if (b_vld && out_ready[1]) got[1].push_back(int'(b_dat));
         if (in_valid[0] && a_rdy) nxt[0]++;
         if (in_valid[1] && b_rdy) nxt[1]++;
         tick();
         cyc++;
      end
      n_chk++;
      if (cyc >= 30) begin
         n_fail++;
         $display("FAIL bp_timeout got %0d/%0d words expected 4", got[0].size(), got[1].size());
      end
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (i >= got[d].size() || got[d][i] != i + 1) begin
               n_fail++;
               $display("FAIL bp_order d%0d idx%0d got %0d expected %0d", d, i,
                        (i < got[d].size()) ? got[d][i] : -1, i + 1);
            end
         end
      n_chk++;
      if (low_rdy != 3) begin
         n_fail++;
         $display("FAIL bp_skid_rdy_low got %0d cycles expected 3", low_rdy);
      end
      #1;
      n_chk++;
      if (a_cnt !== NW'(3) || b_cnt !== NW'(3)) begin
         n_fail++;
         $display("FAIL bp_stall_cnt got %0d/%0d expected 3", a_cnt, b_cnt);
      end
   endtask

   task automatic test_flush();
      for (int s = 0; s < 3; s++) begin
         in_valid  = 2'b11;
         in_data   = {2{DW'(32'hA + s)}};
         in_ctrl   = {2{CW'(8'h5A + s)}};
         out_ready = (s == 2) ? 2'b10 : 2'b00;
         flush     = (s == 2) ? 2'b11 : 2'b00;
         #1;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs(d) !== exp_vec(d)) begin
               n_fail++;
               $display("FAIL flush_setup d%0d got %h expected %h", d, obs(d), exp_vec(d));
            end
         end
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         idle();
         out_ready = 2'b11;
         #1;
         n_chk++;
         if (a_vld !== 1'b0 || a_ctl !== '0 || a_rdy !== 1'b1 || a_dat !== DW'(32'hA)) begin
            n_fail++;
            $display("FAIL flush_skid c%0d got vld=%b ctl=%h rdy=%b dat=%h expected 0 0 1 a",
                     c, a_vld, a_ctl, a_rdy, a_dat);
         end
         n_chk++;
         if (b_vld !== 1'b0 || b_ctl !== '0 || b_dat !== DW'(32'hA)) begin
            n_fail++;
            $display("FAIL flush_flat c%0d got vld=%b ctl=%h dat=%h expected 0 0 a", c, b_vld, b_ctl, b_dat);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      for (int c = 0; c < 21; c++) begin
         idle();
         in_valid = (c == 0) ? 2'b11 : 2'b00;
         in_data  = {2{DW'(32'h77)}};
         in_ctrl  = {2{CW'(8'h33)}};
         #1;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs(d) !== exp_vec(d)) begin
               n_fail++;
               $display("FAIL saturate d%0d c%0d got %h expected %h", d, c, obs(d), exp_vec(d));
            end
         end
         tick();
      end
      n_chk++;
      if (a_cnt !== 4'd15 || b_cnt !== 4'd15) begin
         n_fail++;
         $display("FAIL sat_value got %0d/%0d expected 15", a_cnt, b_cnt);
      end
      flush = 2'b11;
      tick();
      idle();
      #1;
      n_chk++;
      if (a_cnt !== 4'd15 || b_cnt !== 4'd15 || a_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_after_flush got %0d/%0d vld=%b expected 15/15 vld=0", a_cnt, b_cnt, a_vld);
      end
   endtask

   task automatic test_async_reset();
      for (int c = 0; c < 2; c++) begin
         idle();
         in_valid = 2'b11;
         in_data  = {2{DW'(32'h21 + c)}};
         in_ctrl  = {2{CW'(8'hC1 + c)}};
         #1;
         tick();
      end
      idle();
      #3;
      n_chk++;
      if (a_rdy !== 1'b0 || a_vld !== 1'b1 || a_ctl !== CW'(8'hC1)) begin
         n_fail++;
         $display("FAIL areset_pre got rdy=%b vld=%b ctl=%h expected 0 1 c1", a_rdy, a_vld, a_ctl);
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if ({a_rdy, a_vld, a_dat, a_ctl, a_cnt} !== {1'b1, 1'b0, {DW{1'b0}}, {CW{1'b0}}, {NW{1'b0}}}) begin
         n_fail++;
         $display("FAIL areset_skid got %h expected rdy=1 rest 0", obs(0));
      end
      n_chk++;
      if (b_vld !== 1'b0 || b_ctl !== '0 || b_cnt !== '0) begin
         n_fail++;
         $display("FAIL areset_flat got vld=%b ctl=%h cnt=%0d expected 0", b_vld, b_ctl, b_cnt);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 2; d++) begin
            in_valid[d]  = $urandom_range(0, 3) != 0;
            out_ready[d] = (c % 64 < 48) ? ($urandom_range(0, 2) != 0) : 1'b0;
            flush[d]     = $urandom_range(0, 31) == 0;
            in_data[d]   = DW'($urandom);
            in_ctrl[d]   = CW'($urandom);
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs(d) !== exp_vec(d)) begin
               n_fail++;
               $display("FAIL random d%0d c%0d got %h expected %h", d, c, obs(d), exp_vec(d));
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_back_pressure();
      test_flush();
      test_saturation();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
